// File: rtl/game_pkg.sv
// Shared screen-coordinate widths, player box size and slime life-cycle states.
package game_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int PLAYER_W = 32;
  localparam int PLAYER_H = 48;

  typedef enum logic [1:0] {
    WALK_R,
    WALK_L,
    SQUASH,
    DEAD
  } slime_state_t;

  // Half-open interval intersection; touching edges do not count.
  function automatic logic spans_overlap(input logic [10:0] a_lo, input logic [10:0] a_hi,
                                         input logic [10:0] b_lo, input logic [10:0] b_hi);
    return (a_lo < b_hi) && (b_lo < a_hi);
  endfunction

endpackage

// File: rtl/slime_unit.sv
// One patrolling slime: walk/squash/dead FSM, position, step counter and
// player contact classification (stomp vs. side/below damage).
module slime_unit
  import game_pkg::*;
#(
  parameter int X_MIN         = 100,
  parameter int X_MAX         = 300,
  parameter int Y_TOP         = 400,
  parameter int SLIME_W       = 32,
  parameter int SLIME_H       = 24,
  parameter int P_W           = PLAYER_W,
  parameter int P_H           = PLAYER_H,
  parameter int STOMP_BAND    = 8,
  parameter int SQUASH_STEPS  = 25,
  parameter int RESPAWN_STEPS = 150
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           step,
  input  logic [X_W-1:0] player_x,
  input  logic [Y_W-1:0] player_y,
  input  logic           player_falling,
  output logic [X_W-1:0] slime_x,
  output logic           alive,
  output logic           squashed,
  output logic           damage,
  output logic           stomp_hit
);

  localparam int CNT_MAX = (SQUASH_STEPS > RESPAWN_STEPS) ? SQUASH_STEPS : RESPAWN_STEPS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  slime_state_t state, state_nxt;
  logic [X_W-1:0]   x_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             walking, overlap, damage_nxt;
  logic [10:0]      px_lo, px_hi, py_lo, py_hi, sx_lo, sx_hi;

  // 11-bit extents so right/bottom edges never wrap
  assign px_lo = {1'b0, player_x};
  assign px_hi = px_lo + 11'(P_W);
  assign py_lo = {2'b00, player_y};
  assign py_hi = py_lo + 11'(P_H);
  assign sx_lo = {1'b0, slime_x};
  assign sx_hi = sx_lo + 11'(SLIME_W);

  assign walking    = (state == WALK_R) || (state == WALK_L);
  assign overlap    = spans_overlap(px_lo, px_hi, sx_lo, sx_hi) &&
                      spans_overlap(py_lo, py_hi, 11'(Y_TOP), 11'(Y_TOP + SLIME_H));
  assign stomp_hit  = en && walking && overlap && player_falling &&
                      (py_hi <= 11'(Y_TOP + STOMP_BAND));
  assign damage_nxt = en && walking && overlap && !stomp_hit;

  always_comb begin
    state_nxt = state;
    x_nxt     = slime_x;
    cnt_nxt   = cnt;
    if (stomp_hit) begin
      state_nxt = SQUASH;
      cnt_nxt   = '0;
    end else if (step) begin
      case (state)
        WALK_R: begin
          if (slime_x == X_W'(X_MAX)) begin
            x_nxt     = slime_x - 1'b1;
            state_nxt = WALK_L;
          end else begin
            x_nxt = slime_x + 1'b1;
          end
        end
        WALK_L: begin
          if (slime_x == X_W'(X_MIN)) begin
            x_nxt     = slime_x + 1'b1;
            state_nxt = WALK_R;
          end else begin
            x_nxt = slime_x - 1'b1;
          end
        end
        SQUASH: begin
          if (cnt == CNT_W'(SQUASH_STEPS - 1)) begin
            state_nxt = DEAD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        DEAD: begin
          if (cnt == CNT_W'(RESPAWN_STEPS - 1)) begin
            state_nxt = WALK_R;
            x_nxt     = X_W'(X_MIN);
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = WALK_R;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WALK_R;
      slime_x  <= X_W'(X_MIN);
      cnt      <= '0;
      alive    <= 1'b1;
      squashed <= 1'b0;
      damage   <= 1'b0;
    end else begin
      state    <= state_nxt;
      slime_x  <= x_nxt;
      cnt      <= cnt_nxt;
      alive    <= (state_nxt == WALK_R) || (state_nxt == WALK_L);
      squashed <= (state_nxt == SQUASH);
      damage   <= damage_nxt;
    end
  end

endmodule

// File: rtl/slime_ctrl.sv
// Two patrolling slimes sharing one movement tick; registers the combined stomp pulse.
module slime_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV      = 2_000_000,
  parameter int X0_MIN        = 100,
  parameter int X0_MAX        = 300,
  parameter int Y0            = 400,
  parameter int X1_MIN        = 400,
  parameter int X1_MAX        = 600,
  parameter int Y1            = 400,
  parameter int SLIME_W       = 32,
  parameter int SLIME_H       = 24,
  parameter int P_W           = PLAYER_W,
  parameter int P_H           = PLAYER_H,
  parameter int STOMP_BAND    = 8,
  parameter int SQUASH_STEPS  = 25,
  parameter int RESPAWN_STEPS = 150
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [X_W-1:0] player_x,
  input  logic [Y_W-1:0] player_y,
  input  logic           player_falling,
  output logic [X_W-1:0] slime_x0,
  output logic [X_W-1:0] slime_x1,
  output logic [1:0]     slime_alive,
  output logic [1:0]     slime_squashed,
  output logic [1:0]     slim_damage,
  output logic           stomp
);

  localparam int DIV_W = $clog2(TICK_DIV + 1);

  logic [DIV_W-1:0] div_q;
  logic             step;
  logic [1:0]       stomp_hit;

  assign step = en && (div_q == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      stomp <= 1'b0;
    end else begin
      stomp <= |stomp_hit;
      if (en) div_q <= step ? '0 : div_q + 1'b1;
    end
  end

  slime_unit #(
    .X_MIN(X0_MIN), .X_MAX(X0_MAX), .Y_TOP(Y0), .SLIME_W(SLIME_W), .SLIME_H(SLIME_H),
    .P_W(P_W), .P_H(P_H), .STOMP_BAND(STOMP_BAND),
    .SQUASH_STEPS(SQUASH_STEPS), .RESPAWN_STEPS(RESPAWN_STEPS)
  ) u_slime0 (
    .clk(clk), .reset(reset), .en(en), .step(step),
    .player_x(player_x), .player_y(player_y), .player_falling(player_falling),
    .slime_x(slime_x0), .alive(slime_alive[0]), .squashed(slime_squashed[0]),
    .damage(slim_damage[0]), .stomp_hit(stomp_hit[0])
  );

  slime_unit #(
    .X_MIN(X1_MIN), .X_MAX(X1_MAX), .Y_TOP(Y1), .SLIME_W(SLIME_W), .SLIME_H(SLIME_H),
    .P_W(P_W), .P_H(P_H), .STOMP_BAND(STOMP_BAND),
    .SQUASH_STEPS(SQUASH_STEPS), .RESPAWN_STEPS(RESPAWN_STEPS)
  ) u_slime1 (
    .clk(clk), .reset(reset), .en(en), .step(step),
    .player_x(player_x), .player_y(player_y), .player_falling(player_falling),
    .slime_x(slime_x1), .alive(slime_alive[1]), .squashed(slime_squashed[1]),
    .damage(slim_damage[1]), .stomp_hit(stomp_hit[1])
  );

endmodule

// File: tb/tb_slime_ctrl.sv
// Directed bench for slime_ctrl with a 4-cycle movement tick.
module tb_slime_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [9:0] player_x;
  logic [8:0] player_y;
  logic       player_falling;
  logic [9:0] slime_x0, slime_x1;
  logic [1:0] slime_alive, slime_squashed, slim_damage;
  logic       stomp;

  int   n_pass  = 0;
  int   n_total = 0;
  logic track   = 1'b0;
  int   x0_lo   = 1023;
  int   x0_hi   = 0;

  slime_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .en(en),
    .player_x(player_x), .player_y(player_y), .player_falling(player_falling),
    .slime_x0(slime_x0), .slime_x1(slime_x1),
    .slime_alive(slime_alive), .slime_squashed(slime_squashed),
    .slim_damage(slim_damage), .stomp(stomp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (track) begin
      if (int'(slime_x0) < x0_lo) x0_lo = int'(slime_x0);
      if (int'(slime_x0) > x0_hi) x0_hi = int'(slime_x0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    tick(n * TD);
  endtask

  task automatic away();
    player_x       = 10'd900;
    player_y       = 9'd0;
    player_falling = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    en = 1'b1;
    away();
    reset = 1'b1;
    tick(3);
    chk("rst_x0", slime_x0, 100);
    chk("rst_x1", slime_x1, 400);
    chk("rst_alive", slime_alive, 2'b11);
    chk("rst_squashed", slime_squashed, 2'b00);
    chk("rst_damage", slim_damage, 2'b00);
    chk("rst_stomp", stomp, 0);

    reset = 1'b0;
    steps(4);
    chk("walk4_x0", slime_x0, 104);
    chk("walk4_x1", slime_x1, 404);
    chk("walk4_alive", slime_alive, 2'b11);
    chk("walk4_damage", slim_damage, 2'b00);

    track = 1'b1;
    steps(196);
    chk("at_max_x0", slime_x0, 300);
    chk("at_max_x1", slime_x1, 600);
    steps(1);
    chk("rev_max_x0", slime_x0, 299);
    chk("rev_max_x1", slime_x1, 599);
    steps(199);
    chk("at_min_x0", slime_x0, 100);
    chk("at_min_x1", slime_x1, 400);
    steps(1);
    chk("rev_min_x0", slime_x0, 101);
    chk("rev_min_x1", slime_x1, 401);
    track = 1'b0;
    chk("x0_never_below_min", x0_lo, 100);
    chk("x0_never_above_max", x0_hi, 300);

    // side contact on slime 0 (x0 = 101)
    player_x = 10'd111;
    player_y = 9'd380;
    chk("dmg_latency", slim_damage, 2'b00);
    tick(1);
    chk("dmg_set", slim_damage, 2'b01);
    tick(2);
    chk("dmg_held", slim_damage, 2'b01);
    away();
    tick(1);
    chk("dmg_clear", slim_damage, 2'b00);
    chk("dmg_x0", slime_x0, 102);

    // edges exactly touching, then one pixel of overlap
    player_x = 10'd70;
    player_y = 9'd380;
    tick(2);
    chk("touch_no_dmg", slim_damage, 2'b00);
    player_x = 10'd71;
    tick(1);
    chk("one_px_dmg", slim_damage, 2'b01);
    away();
    tick(1);
    chk("touch_clear", slim_damage, 2'b00);
    chk("touch_x0", slime_x0, 103);

    // frozen while a stomp condition on slime 1 is present
    en = 1'b0;
    player_x       = 10'd408;
    player_y       = 9'd356;
    player_falling = 1'b1;
    steps(20);
    chk("frz_x0", slime_x0, 103);
    chk("frz_x1", slime_x1, 403);
    chk("frz_damage", slim_damage, 2'b00);
    chk("frz_stomp", stomp, 0);
    chk("frz_squashed", slime_squashed, 2'b00);

    en = 1'b1;
    tick(1);
    chk("stomp_pulse", stomp, 1);
    chk("stomp_no_dmg", slim_damage, 2'b00);
    chk("stomp_squashed", slime_squashed, 2'b10);
    chk("stomp_alive", slime_alive, 2'b01);
    tick(1);
    chk("stomp_single", stomp, 0);
    chk("stomp_still_sq", slime_squashed, 2'b10);
    away();
    tick(2);
    steps(23);
    chk("squash24", slime_squashed, 2'b10);
    steps(1);
    chk("squash25_sq", slime_squashed, 2'b00);
    chk("squash25_alive", slime_alive, 2'b01);
    steps(149);
    chk("dead149_alive", slime_alive, 2'b01);
    steps(1);
    chk("respawn_alive", slime_alive, 2'b11);
    chk("respawn_x1", slime_x1, 400);

    // falling, bottom one pixel below the stomp band -> damage
    player_x       = 10'd405;
    player_y       = 9'd361;
    player_falling = 1'b1;
    tick(1);
    chk("deep_dmg", slim_damage, 2'b10);
    chk("deep_no_stomp", stomp, 0);
    player_y = 9'd360;
    tick(1);
    chk("band_stomp", stomp, 1);
    chk("band_no_dmg", slim_damage, 2'b00);
    chk("band_squashed", slime_squashed, 2'b10);
    away();
    tick(2);
    steps(24);
    chk("dead2_alive", slime_alive, 2'b01);
    chk("dead2_sq", slime_squashed, 2'b00);
    steps(10);

    // asynchronous reset while slime 1 is dead
    #2 reset = 1'b1;
    #1;
    chk("arst_x0", slime_x0, 100);
    chk("arst_x1", slime_x1, 400);
    chk("arst_alive", slime_alive, 2'b11);
    chk("arst_squashed", slime_squashed, 2'b00);
    chk("arst_damage", slim_damage, 2'b00);
    chk("arst_stomp", stomp, 0);
    tick(2);
    reset = 1'b0;
    steps(1);
    chk("post_rst_x0", slime_x0, 101);
    chk("post_rst_x1", slime_x1, 401);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
